// File: rtl/dsc_mul_n.sv
// -----------------------------------------------------------------------------
// dsc_mul_n
// Deterministic stochastic-computing multiplier for NUM_IN unsigned operands of
// WIDTH bits each. Every operand becomes a unary bitstream by comparing it with
// its own counter. The counters are chained as a mixed-radix odometer, so each
// combination of stream bits occurs exactly once over 2^(WIDTH*NUM_IN) cycles.
// Counting the cycles where all streams are 1 gives the exact product.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   en     in   global enable; low freezes all state
//   start  in   launch request, taken only in IDLE with en=1
//   a_in   in   packed operands, operand k = a_in[k*WIDTH +: WIDTH]
//   ready  out  high in IDLE
//   busy   out  high in RUN
//   done   out  high for the single DONE cycle; z is valid
//   z      out  product, held until the next accepted start
//
// Optional feature
//   DSC_MUL_N_ZERO_SKIP_EN : when defined, an operand equal to zero at
//   acceptance sends the FSM straight to DONE with z=0 and skips RUN.
// -----------------------------------------------------------------------------
module dsc_mul_n #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  input  logic [WIDTH*NUM_IN-1:0] a_in,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH*NUM_IN-1:0] z
);

  localparam int ZW = WIDTH * NUM_IN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] op_q    [NUM_IN];
  logic [WIDTH-1:0] ctr_q   [NUM_IN];
  logic [WIDTH-1:0] ctr_nxt [NUM_IN];
  logic             all_max;
  logic             hit;
  logic             accept;
  logic             skip_run;

  assign accept = en && (state_q == S_IDLE) && start;

  // Odometer step and stream AND. The carry into counter k is high only when
  // every lower counter sits at its maximum; the carry out of the top counter
  // therefore marks the last combination of the sweep.
  always_comb begin
    logic carry;
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    carry = 1'b1;
    hit   = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      ctr_nxt[k] = carry ? ctr_q[k] + WIDTH'(1) : ctr_q[k];
      hit        = hit & (op_q[k] > ctr_q[k]);
      carry      = carry & (ctr_q[k] == {WIDTH{1'b1}});
    end
    all_max = carry;
  end

`ifdef DSC_MUL_N_ZERO_SKIP_EN
  // Any zero operand forces a zero product, so the sweep can be skipped.
  always_comb begin
    skip_run = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (a_in[k*WIDTH +: WIDTH] == '0) skip_run = 1'b1;
    end
  end
`else
  assign skip_run = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        S_IDLE:  if (start) state_d = skip_run ? S_DONE : S_RUN;
        S_RUN:   if (all_max) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode the state register only, so no input reaches them
  // combinationally.
  always_comb begin
    ready = (state_q == S_IDLE);
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
  end

  // Operand latch, odometer counters and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the operand and counter arrays are plain flops, not RAM, so they
      // are cleared element by element along with the rest of the state.
      for (int k = 0; k < NUM_IN; k++) begin
        op_q[k]  <= '0;
        ctr_q[k] <= '0;
      end
      z <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_IN; k++) begin
        op_q[k]  <= a_in[k*WIDTH +: WIDTH];
        ctr_q[k] <= '0;
      end
      z <= '0;
    end else if (en && (state_q == S_RUN)) begin
      // After the final sweep step the counters wrap to zero, which is
      // harmless because RUN is left on that same edge.
      for (int k = 0; k < NUM_IN; k++) begin
        ctr_q[k] <= ctr_nxt[k];
      end
      // (2^WIDTH-1)^NUM_IN < 2^ZW, so the accumulator never wraps.
      if (hit) z <= z + ZW'(1);
    end
  end

endmodule

// File: tb/tb_dsc_mul_n.sv
// -----------------------------------------------------------------------------
// tb_dsc_mul_n
// Three instances share one clock:
//   dut_a  WIDTH=4, NUM_IN=3  directed scenarios plus a cycle-by-cycle model
//   dut_b  WIDTH=8, NUM_IN=2  200*100 full sweep
//   dut_c  WIDTH=4, NUM_IN=2  random operand pairs
// -----------------------------------------------------------------------------
module tb_dsc_mul_n;

`ifdef DSC_MUL_N_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- dut_a
  logic        rst   = 1'b1;
  logic        en    = 1'b1;
  logic        start = 1'b0;
  logic [11:0] a_in  = '0;
  logic        ready, busy, done;
  logic [11:0] z;

  dsc_mul_n #(.WIDTH(4), .NUM_IN(3)) dut_a (
    .clk(clk), .rst(rst), .en(en), .start(start), .a_in(a_in),
    .ready(ready), .busy(busy), .done(done), .z(z)
  );

  // Transaction-level model: an accepted operation takes 4096 enabled edges
  // in RUN and then yields the plain product of its operands.
  int m_phase = 0;   // 0 idle, 1 run, 2 done
  int m_left  = 0;
  int m_prod  = 0;
  int m_z     = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_z     <= 0;
      m_left  <= 0;
    end else if (en) begin
      case (m_phase)
        0: if (start) begin
          m_prod <= int'(a_in[3:0]) * int'(a_in[7:4]) * int'(a_in[11:8]);
          m_z    <= 0;
          if (SKIP && (a_in[3:0] == 0 || a_in[7:4] == 0 || a_in[11:8] == 0)) begin
            m_phase <= 2;
          end else begin
            m_phase <= 1;
            m_left  <= 4096;
          end
        end
        1: if (m_left == 1) begin
          m_phase <= 2;
          m_z     <= m_prod;
        end else begin
          m_left <= m_left - 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_ready", ready, m_phase == 0);
      check("model_busy",  busy,  m_phase == 1);
      check("model_done",  done,  m_phase == 2);
      if (m_phase != 1) check("model_z", z, m_z);
    end
  end

  // Called at a negedge: presents operands and start, returns after the
  // accepting edge with t0 = that edge's index.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        output int t0);
    a_in  = {c, b, a};
    start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
  endtask

  // Drops start on the first negedge, then waits for done; returns the
  // latency in edges, or -1 if the bound ran out.
  task automatic wait_done(input int t0, input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------- dut_b
  logic        rst_bc  = 1'b1;
  logic        start_b = 1'b0;
  logic [15:0] a_in_b  = '0;
  logic        ready_b, busy_b, done_b;
  logic [15:0] z_b;
  bit          b_fin = 1'b0;

  dsc_mul_n #(.WIDTH(8), .NUM_IN(2)) dut_b (
    .clk(clk), .rst(rst_bc), .en(1'b1), .start(start_b), .a_in(a_in_b),
    .ready(ready_b), .busy(busy_b), .done(done_b), .z(z_b)
  );

  initial begin
    int t0, lat;
    wait (rst_bc == 1'b0);
    @(negedge clk);
    a_in_b  = {8'd100, 8'd200};
    start_b = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    lat = -1;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
    check("w8_latency", lat, 65536);
    check("w8_z", z_b, 20000);
    b_fin = 1'b1;
  end

  // ---------------------------------------------------------------- dut_c
  logic       start_c = 1'b0;
  logic [7:0] a_in_c  = '0;
  logic       ready_c, busy_c, done_c;
  logic [7:0] z_c;
  bit         c_fin = 1'b0;

  dsc_mul_n #(.WIDTH(4), .NUM_IN(2)) dut_c (
    .clk(clk), .rst(rst_bc), .en(1'b1), .start(start_c), .a_in(a_in_c),
    .ready(ready_c), .busy(busy_c), .done(done_c), .z(z_c)
  );

  initial begin
    int t0, lat, pa, pb;
    wait (rst_bc == 1'b0);
    for (int n = 0; n < 14; n++) begin
      if (n == 0) begin
        pa = 15; pb = 15;
      end else if (n == 1) begin
        pa = 0;  pb = 9;
      end else begin
        pa = int'($urandom_range(15, 1));
        pb = int'($urandom_range(15, 1));
      end
      @(negedge clk);
      a_in_c  = {4'(pb), 4'(pa)};
      start_c = 1'b1;
      @(posedge clk);
      #1 t0 = cyc;
      lat = -1;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        start_c = 1'b0;
        if (done_c === 1'b1) begin
          lat = cyc - t0;
          break;
        end
      end
      check("pair_latency", lat, (SKIP && (pa == 0 || pb == 0)) ? 1 : 256);
      check("pair_z", z_c, pa * pb);
    end
    c_fin = 1'b1;
  end

  // ---------------------------------------------------------------- main
  initial begin
    int t0, t1, lat;

    #12;
    check("rst_ready", ready, 1);
    check("rst_busy",  busy,  0);
    check("rst_done",  done,  0);
    check("rst_z",     z,     0);
    @(negedge clk);
    rst    = 1'b0;
    rst_bc = 1'b0;

    // Full-scale operands.
    @(negedge clk);
    run_op(4'd15, 4'd15, 4'd15, t0);
    wait_done(t0, 5000, lat);
    check("full_latency", lat, 4096);
    check("full_z", z, 3375);
    @(negedge clk);
    check("full_ready_after", ready, 1);

    // Zero operand.
    run_op(4'd5, 4'd0, 4'd9, t0);
    wait_done(t0, 5000, lat);
    check("zero_latency", lat, SKIP ? 1 : 4096);
    check("zero_z", z, 0);

    // Enable stall of 100 cycles, and a start pulse with new operands
    // while busy.
    @(negedge clk);
    run_op(4'd7, 4'd3, 4'd11, t0);
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    en = 1'b0;
    repeat (100) @(negedge clk);
    en = 1'b1;
    check("stall_busy", busy, 1);
    @(negedge clk);
    a_in  = 12'hfff;
    start = 1'b1;
    wait_done(t0, 6000, lat);
    check("stall_latency", lat, 4196);
    check("stall_z", z, 231);

    // Asynchronous reset mid-run.
    @(negedge clk);
    run_op(4'd15, 4'd15, 4'd15, t0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 1000) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_z",     z,     0);
    check("arst_busy",  busy,  0);
    check("arst_ready", ready, 1);
    check("arst_done",  done,  0);
    @(negedge clk);
    rst = 1'b0;

    // Restart after reset.
    @(negedge clk);
    run_op(4'd2, 4'd3, 4'd4, t0);
    wait_done(t0, 5000, lat);
    check("restart_latency", lat, 4096);
    check("restart_z", z, 24);

    // Back-to-back: start on the first ready cycle after done.
    @(negedge clk);
    check("b2b_ready", ready, 1);
    check("b2b_z_held", z, 24);
    run_op(4'd1, 4'd2, 4'd3, t1);
    check("b2b_spacing", t1 - t0, 4098);
    wait_done(t1, 5000, lat);
    check("b2b_latency", lat, 4096);
    check("b2b_z", z, 6);

    for (int i = 0; i < 80000 && !(b_fin && c_fin); i++) @(negedge clk);
    check("side_instances_finished", b_fin && c_fin, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
